// File: rtl/pb_hw_pkg.sv
// Shared types for the protobuf wire-format front end: wire types, error
// codes, parser states and the varint length limit.
package pb_hw_pkg;

  localparam int MAX_VARINT_BYTES = 10;

  typedef enum logic [2:0] {
    WT_VARINT  = 3'd0,
    WT_FIXED64 = 3'd1,
    WT_LEN     = 3'd2,
    WT_FIXED32 = 3'd5
  } pb_wire_type_e;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_VARINT_TOO_LONG = 3'd1,
    ERR_BAD_WIRE_TYPE   = 3'd2,
    ERR_BAD_FIELD       = 3'd3,
    ERR_LEN_TOO_BIG     = 3'd4,
    ERR_TRUNCATED       = 3'd5
  } pb_err_e;

  typedef enum logic [2:0] {
    ST_KEY     = 3'd0,
    ST_VARINT  = 3'd1,
    ST_FIXED   = 3'd2,
    ST_LEN     = 3'd3,
    ST_EMIT    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_DRAIN   = 3'd6
  } pb_parse_state_e;

  function automatic logic wt_supported(input logic [2:0] wt);
    return (wt == WT_VARINT) || (wt == WT_FIXED64) ||
           (wt == WT_LEN) || (wt == WT_FIXED32);
  endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// Byte-serial LEB128 varint accumulator shared by the key, varint and length
// phases. value_o already includes the byte presented on byte_i this cycle.
module pb_varint_accum
  import pb_hw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] value_o,
  output logic        done_o,
  output logic        too_long_o
);

  logic [63:0] acc_q;
  logic [3:0]  cnt_q;
  logic [6:0]  shamt;

  localparam logic [3:0] LAST_IDX = 4'(MAX_VARINT_BYTES - 1);

  // Bits of the 10th group above bit 63 fall off the 64-bit shift.
  always_comb begin
    shamt      = 7'(7 * cnt_q);
    value_o    = acc_q | (64'(byte_i[6:0]) << shamt);
    done_o     = strobe_i && !byte_i[7];
    too_long_o = strobe_i && byte_i[7] && (cnt_q == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (strobe_i) begin
      acc_q <= value_o;
      if (cnt_q != LAST_IDX) cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/pb_field_parser.sv
// Streaming protobuf field splitter: one byte in per cycle, one descriptor per
// field, LEN payload passed through. Optional PB_FIELD_PARSER_STATS_EN adds counters.
// Handshakes: a transfer happens on a cycle where valid && ready; a producer
// holds valid and its data stable until that cycle.
module pb_field_parser
  import pb_hw_pkg::*;
#(
  parameter int MAX_LEN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            fld_valid,
  input  logic            fld_ready,
  output logic [31:0]     fld_number,
  output logic [2:0]      fld_wire_type,
  output logic [63:0]     fld_value,
  output logic            fld_last,
  output logic            pay_valid,
  input  logic            pay_ready,
  output logic [7:0]      pay_data,
  output logic            pay_last,
  output logic            err,
  output logic [2:0]      err_code,
`ifdef PB_FIELD_PARSER_STATS_EN
  output logic [31:0]     stat_fields,
  output logic [31:0]     stat_errors,
`endif
  output pb_parse_state_e dbg_state
);

  pb_parse_state_e      state_q, state_d;
  logic [2:0]           wt_q, wt_d;
  logic [31:0]          num_q, num_d;
  logic [63:0]          val_q, val_d;
  logic                 last_q, last_d;
  logic [2:0]           fix_idx_q, fix_idx_d;
  logic [MAX_LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic                 err_q, err_d;
  pb_err_e              err_code_q, err_code_d;

  logic                 accept;
  logic                 fail;
  pb_err_e              fail_code;
  logic                 acc_clear, acc_strobe, acc_done, acc_too_long;
  logic [63:0]          acc_value;
  logic [2:0]           fix_last_idx;

  pb_varint_accum u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (acc_clear),
    .strobe_i   (acc_strobe),
    .byte_i     (in_data),
    .value_o    (acc_value),
    .done_o     (acc_done),
    .too_long_o (acc_too_long)
  );

  always_comb begin
    case (state_q)
      ST_EMIT:    in_ready = 1'b0;
      ST_PAYLOAD: in_ready = pay_ready;
      default:    in_ready = 1'b1;
    endcase
  end

  assign accept       = in_valid && in_ready;
  assign fix_last_idx = (wt_q == WT_FIXED64) ? 3'd7 : 3'd3;

  always_comb begin
    state_d    = state_q;
    wt_d       = wt_q;
    num_d      = num_q;
    val_d      = val_q;
    last_d     = last_q;
    fix_idx_d  = fix_idx_q;
    pay_cnt_d  = pay_cnt_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    acc_clear  = 1'b1;
    acc_strobe = 1'b0;
    fld_valid  = 1'b0;
    fld_last   = 1'b0;
    pay_valid  = 1'b0;
    pay_data   = 8'h00;
    pay_last   = 1'b0;

    case (state_q)
      ST_KEY: begin
        acc_strobe = accept;
        acc_clear  = accept && (acc_done || acc_too_long || in_last);
        if (accept) begin
          if (acc_too_long) begin
            fail = 1'b1; fail_code = ERR_VARINT_TOO_LONG;
          end else if (acc_done) begin
            if (acc_value[63:3] == '0) begin
              fail = 1'b1; fail_code = ERR_BAD_FIELD;
            end else if (!wt_supported(acc_value[2:0])) begin
              fail = 1'b1; fail_code = ERR_BAD_WIRE_TYPE;
            end else if (in_last) begin
              fail = 1'b1; fail_code = ERR_TRUNCATED;
            end else begin
              num_d     = acc_value[34:3];
              wt_d      = acc_value[2:0];
              val_d     = '0;
              last_d    = 1'b0;
              fix_idx_d = '0;
              if (acc_value[2:0] == WT_VARINT)   state_d = ST_VARINT;
              else if (acc_value[2:0] == WT_LEN) state_d = ST_LEN;
              else                               state_d = ST_FIXED;
            end
          end else if (in_last) begin
            fail = 1'b1; fail_code = ERR_TRUNCATED;
          end
        end
      end

      ST_VARINT, ST_LEN: begin
        acc_strobe = accept;
        acc_clear  = accept && (acc_done || acc_too_long || in_last);
        if (accept) begin
          if (acc_too_long) begin
            fail = 1'b1; fail_code = ERR_VARINT_TOO_LONG;
          end else if (acc_done) begin
            if (state_q == ST_VARINT) begin
              val_d   = acc_value;
              last_d  = in_last;
              state_d = ST_EMIT;
            end else if ((acc_value >> MAX_LEN_W) != '0) begin
              fail = 1'b1; fail_code = ERR_LEN_TOO_BIG;
            end else if (acc_value == '0) begin
              val_d   = '0;
              last_d  = in_last;
              state_d = ST_EMIT;
            end else if (in_last) begin
              // A non-empty payload cannot follow the final byte.
              fail = 1'b1; fail_code = ERR_TRUNCATED;
            end else begin
              val_d     = acc_value;
              pay_cnt_d = acc_value[MAX_LEN_W-1:0];
              last_d    = 1'b0;
              state_d   = ST_EMIT;
            end
          end else if (in_last) begin
            fail = 1'b1; fail_code = ERR_TRUNCATED;
          end
        end
      end

      ST_FIXED: begin
        if (accept) begin
          val_d[{fix_idx_q, 3'b000} +: 8] = in_data;
          fix_idx_d = fix_idx_q + 3'd1;
          if (fix_idx_q == fix_last_idx) begin
            last_d  = in_last;
            state_d = ST_EMIT;
          end else if (in_last) begin
            fail = 1'b1; fail_code = ERR_TRUNCATED;
          end
        end
      end

      ST_EMIT: begin
        fld_valid = 1'b1;
        fld_last  = last_q;
        if (fld_ready) begin
          state_d = ((wt_q == WT_LEN) && (val_q != '0)) ? ST_PAYLOAD : ST_KEY;
        end
      end

      ST_PAYLOAD: begin
        pay_valid = in_valid;
        pay_data  = in_data;
        pay_last  = (pay_cnt_q == MAX_LEN_W'(1));
        fld_last  = in_valid && pay_last && in_last;
        if (accept) begin
          pay_cnt_d = pay_cnt_q - MAX_LEN_W'(1);
          if (pay_last) begin
            state_d = ST_KEY;
          end else if (in_last) begin
            fail = 1'b1; fail_code = ERR_TRUNCATED;
          end
        end
      end

      ST_DRAIN: begin
        if (accept && in_last) state_d = ST_KEY;
      end

      default: state_d = ST_KEY;
    endcase

    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      state_d    = in_last ? ST_KEY : ST_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_KEY;
      wt_q       <= '0;
      num_q      <= '0;
      val_q      <= '0;
      last_q     <= 1'b0;
      fix_idx_q  <= '0;
      pay_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wt_q       <= wt_d;
      num_q      <= num_d;
      val_q      <= val_d;
      last_q     <= last_d;
      fix_idx_q  <= fix_idx_d;
      pay_cnt_q  <= pay_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign fld_number    = num_q;
  assign fld_wire_type = wt_q;
  assign fld_value     = val_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign dbg_state     = state_q;

`ifdef PB_FIELD_PARSER_STATS_EN
  logic [31:0] stat_fields_q, stat_errors_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fields_q <= '0;
      stat_errors_q <= '0;
    end else begin
      if (fld_valid && fld_ready && (stat_fields_q != '1)) stat_fields_q <= stat_fields_q + 32'd1;
      if (err_q && (stat_errors_q != '1))                  stat_errors_q <= stat_errors_q + 32'd1;
    end
  end

  assign stat_fields = stat_fields_q;
  assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_pb_field_parser.sv
// Bench for pb_field_parser: directed and random messages, checked against a
// sequential software-style decoder of each message.
module tb_pb_field_parser;
  import pb_hw_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_data = 8'h00;
  logic            in_last = 1'b0;
  logic            fld_valid;
  logic            fld_ready = 1'b1;
  logic [31:0]     fld_number;
  logic [2:0]      fld_wire_type;
  logic [63:0]     fld_value;
  logic            fld_last;
  logic            pay_valid;
  logic            pay_ready = 1'b1;
  logic [7:0]      pay_data;
  logic            pay_last;
  logic            err;
  logic [2:0]      err_code;
  pb_parse_state_e dbg_state;
`ifdef PB_FIELD_PARSER_STATS_EN
  logic [31:0]     stat_fields, stat_errors;
`endif

  pb_field_parser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .fld_valid     (fld_valid),
    .fld_ready     (fld_ready),
    .fld_number    (fld_number),
    .fld_wire_type (fld_wire_type),
    .fld_value     (fld_value),
    .fld_last      (fld_last),
    .pay_valid     (pay_valid),
    .pay_ready     (pay_ready),
    .pay_data      (pay_data),
    .pay_last      (pay_last),
    .err           (err),
    .err_code      (err_code),
`ifdef PB_FIELD_PARSER_STATS_EN
    .stat_fields   (stat_fields),
    .stat_errors   (stat_errors),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit stall_en = 1'b0;

  logic [7:0]  msg_q[$];
  logic [99:0] exp_fld_q[$];
  logic [9:0]  exp_pay_q[$];
  logic [2:0]  exp_err_q[$];
  int tot_fld = 0;
  int tot_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_err(input pb_err_e e);
    exp_err_q.push_back(3'(e));
    tot_err++;
  endtask

  task automatic push_fld(input logic [63:0] fnum, input logic [2:0] wt, input logic [63:0] v, input logic l);
    exp_fld_q.push_back({fnum[31:0], wt, v, l});
    tot_fld++;
  endtask

  // st: 0 ok, else error code
  task automatic read_varint(inout int i, output logic [63:0] v, output int st);
    logic [7:0] b;
    v  = '0;
    st = -1;
    for (int k = 0; k < 10 && st < 0; k++) begin
      b = msg_q[i];
      i++;
      v = v | (64'(b[6:0]) << (7 * k));
      if (!b[7])                  st = 0;
      else if (k == 9)            st = int'(ERR_VARINT_TOO_LONG);
      else if (i >= msg_q.size()) st = int'(ERR_TRUNCATED);
    end
  endtask

  task automatic model_msg();
    int n, i, st, nb;
    logic [63:0] key, v, fnum;
    logic [2:0]  wt;
    logic [7:0]  b;
    n = msg_q.size();
    i = 0;
    while (i < n) begin
      read_varint(i, key, st);
      if (st != 0) begin push_err(pb_err_e'(st)); return; end
      fnum = key >> 3;
      wt   = key[2:0];
      if (fnum == 0) begin push_err(ERR_BAD_FIELD); return; end
      if (!(wt == 0 || wt == 1 || wt == 2 || wt == 5)) begin push_err(ERR_BAD_WIRE_TYPE); return; end
      if (i >= n) begin push_err(ERR_TRUNCATED); return; end
      if (wt == 0) begin
        read_varint(i, v, st);
        if (st != 0) begin push_err(pb_err_e'(st)); return; end
        push_fld(fnum, wt, v, i >= n);
      end else if (wt == 1 || wt == 5) begin
        nb = (wt == 1) ? 8 : 4;
        if (n - i < nb) begin push_err(ERR_TRUNCATED); return; end
        v = '0;
        for (int j = 0; j < nb; j++) v = v | (64'(msg_q[i + j]) << (8 * j));
        i += nb;
        push_fld(fnum, wt, v, i >= n);
      end else begin
        read_varint(i, v, st);
        if (st != 0) begin push_err(pb_err_e'(st)); return; end
        if (v >= 64'h1_0000_0000) begin push_err(ERR_LEN_TOO_BIG); return; end
        if (v == 0) begin
          push_fld(fnum, wt, v, i >= n);
        end else if (i >= n) begin
          push_err(ERR_TRUNCATED); return;
        end else begin
          push_fld(fnum, wt, v, 1'b0);
          for (logic [63:0] j = 0; j < v; j++) begin
            b = msg_q[i];
            i++;
            exp_pay_q.push_back({b, j == v - 1, (j == v - 1) && (i >= n)});
            if (i >= n && j != v - 1) begin push_err(ERR_TRUNCATED); return; end
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic push_varint(input logic [63:0] v);
    do begin
      msg_q.push_back({(v > 64'd127), v[6:0]});
      v = v >> 7;
    end while (v != 0);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic l);
    int gap;
    bit acc;
    int budget;
    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    budget   = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 1000);
    if (!acc) check_eq("in_accept_timeout", 0, 1);
  endtask

  task automatic send_msg();
    model_msg();
    foreach (msg_q[k]) drive_byte(msg_q[k], k == msg_q.size() - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b0, input int len, input logic [7:0] fill);
    msg_q.delete();
    msg_q.push_back(b0);
    for (int k = 1; k < len; k++) msg_q.push_back(fill);
  endtask

  task automatic gen_msg();
    int nf, sel;
    logic [63:0] fnum, v;
    msg_q.delete();
    nf = $urandom_range(1, 4);
    for (int f = 0; f < nf; f++) begin
      fnum = ($urandom_range(0, 7) == 0) ? 64'($urandom) : 64'($urandom_range(1, 20));
      sel  = $urandom_range(0, 15);
      if (sel <= 3) begin
        push_varint((fnum << 3) | 64'd0);
        v = {$urandom, $urandom};
        push_varint(v >> $urandom_range(0, 63));
      end else if (sel <= 5 || sel == 10 || sel == 11) begin
        push_varint((fnum << 3) | ((sel <= 5) ? 64'd1 : 64'd5));
        repeat ((sel <= 5) ? 8 : 4) msg_q.push_back(8'($urandom));
      end else if (sel <= 9 || sel == 15) begin
        v = (sel == 15) ? 64'd0 : 64'($urandom_range(1, 6));
        push_varint((fnum << 3) | 64'd2);
        push_varint(v);
        repeat (int'(v)) msg_q.push_back(8'($urandom));
      end else if (sel == 12) begin
        push_varint((fnum << 3) | 64'($urandom_range(0, 1) ? $urandom_range(3, 4) : $urandom_range(6, 7)));
      end else if (sel == 13) begin
        push_varint((fnum << 3) | 64'd2);
        push_varint(64'h1_0000_0000 + 64'($urandom_range(0, 5)));
      end else begin
        push_varint((fnum << 3) | 64'd0);
        repeat (9) msg_q.push_back(8'h80);
        msg_q.push_back(8'h81);
        msg_q.push_back(8'h01);
      end
    end
    if ($urandom_range(0, 5) == 0) begin
      v = 64'($urandom_range(1, msg_q.size()));
      while (msg_q.size() > int'(v)) void'(msg_q.pop_back());
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500 && (exp_fld_q.size() != 0 || exp_pay_q.size() != 0 || exp_err_q.size() != 0); c++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_fld_q", exp_fld_q.size(), 0);
    check_eq("idle_pay_q", exp_pay_q.size(), 0);
    check_eq("idle_err_q", exp_err_q.size(), 0);
  endtask

  // ---------------- consumer back-pressure ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      fld_ready = !stall_en || ($urandom_range(0, 2) != 0);
      pay_ready = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [2:0]  last_code = 3'd0;
  logic        prev_fld_stall = 1'b0, prev_pay_stall = 1'b0;
  logic [99:0] prev_fld, got_fld;
  logic [9:0]  prev_pay, got_pay;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_code      = 3'd0;
        prev_fld_stall = 1'b0;
        prev_pay_stall = 1'b0;
      end else begin
        got_fld = {fld_number, fld_wire_type, fld_value, fld_last};
        got_pay = {pay_data, pay_last, fld_last};
        check_eq("fld_pay_exclusive", fld_valid && pay_valid, 0);
        if (prev_fld_stall) check_eq("fld_hold", {fld_valid, got_fld}, {1'b1, prev_fld});
        if (prev_pay_stall) check_eq("pay_hold", {pay_valid, got_pay}, {1'b1, prev_pay});
        prev_fld_stall = fld_valid && !fld_ready;
        prev_pay_stall = pay_valid && !pay_ready;
        prev_fld = got_fld;
        prev_pay = got_pay;
        if (fld_valid && fld_ready) begin
          if (exp_fld_q.size() == 0) check_eq("fld_unexpected", got_fld, 0);
          else                       check_eq("fld", got_fld, exp_fld_q.pop_front());
        end
        if (pay_valid && pay_ready) begin
          if (exp_pay_q.size() == 0) check_eq("pay_unexpected", got_pay, 0);
          else                       check_eq("pay", got_pay, exp_pay_q.pop_front());
        end
        if (err) begin
          if (exp_err_q.size() == 0) check_eq("err_unexpected", err_code, 0);
          else begin
            last_code = exp_err_q.pop_front();
            check_eq("err_code", err_code, last_code);
          end
        end else begin
          check_eq("err_code_hold", err_code, last_code);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (90000) @(posedge clk);
    check_eq("global_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    in_data = 8'hAB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_fld_valid", fld_valid, 0);
    check_eq("rst_pay_valid", pay_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_fld_data", {fld_number, fld_wire_type, fld_value, fld_last}, 0);
    check_eq("rst_pay_data", {pay_data, pay_last}, 0);
    check_eq("rst_state", dbg_state, ST_KEY);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    in_data = 8'h00;

    // 08 96 01
    msg_q = '{8'h08, 8'h96, 8'h01};
    send_msg();
    // 12 07 "testing"
    msg_q = '{8'h12, 8'h07, 8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h67};
    send_msg();
    // fixed32 then fixed64 all-ones
    msg_q = '{8'h1D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_msg();
    // overlong varint value, trailing bytes drained
    send_bytes(8'h08, 11, 8'h80);
    msg_q.push_back(8'h05);
    msg_q.push_back(8'h06);
    send_msg();
    msg_q = '{8'h10, 8'h2A};
    send_msg();
    msg_q = '{8'h0B};
    send_msg();
    msg_q = '{8'h00};
    send_msg();
    msg_q = '{8'h08, 8'h96};
    send_msg();
    msg_q = '{8'h12, 8'h00, 8'h08, 8'h01};
    send_msg();
    wait_idle();

    stall_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      msg_q = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
      send_msg();
    end
    wait_idle();

    // abort mid-field: nothing from the partial field may appear
    drive_byte(8'h08, 1'b0);
    drive_byte(8'h96, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_state", dbg_state, ST_KEY);
    check_eq("midrst_outs", {fld_valid, pay_valid, err, err_code, in_ready}, 7'b0000001);
    tot_fld = 0;
    tot_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    msg_q = '{8'h08, 8'h01};
    send_msg();
    wait_idle();

    for (int r = 0; r < 250; r++) begin
      gen_msg();
      send_msg();
    end
    wait_idle();

`ifdef PB_FIELD_PARSER_STATS_EN
    check_eq("stat_fields", stat_fields, tot_fld);
    check_eq("stat_errors", stat_errors, tot_err);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pb_field_parser.md
Name: pb_field_parser

Overview:
- Streaming hardware front end for protobuf wire-format messages. Consumes one byte per cycle of a serialized message.
- Splits each field into a descriptor: field number, wire type, and value or length. Length-delimited payload bytes pass through on a separate stream.
- Sits directly downstream of the byte source (DMA/host FIFO) and upstream of per-message field decoders. It is the RTL counterpart of the software varint/key/string decode routines.

Parameters:
- MAX_LEN_W, 32, max width of a length-delimited length; larger lengths are errors.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  input byte accepted when in_valid&&in_ready
- in_data  input  8  message byte
- in_last  input  1  final byte of message
- fld_valid  output  1  field descriptor valid
- fld_ready  input  1  descriptor consumer ready
- fld_number  output  32  field number (key>>3)
- fld_wire_type  output  3  wire type (key&7)
- fld_value  output  64  varint value, fixed value (zero-extended), or payload length
- fld_last  output  1  field ended on in_last
- pay_valid  output  1  payload byte valid
- pay_ready  input  1  payload consumer ready
- pay_data  output  8  payload byte
- pay_last  output  1  last payload byte of field
- err  output  1  one-cycle error pulse
- err_code  output  3  pb_err_e, held until next error

Behaviour:
- Reset: state KEY; in_ready=1; fld_valid=0; pay_valid=0; err=0; err_code=ERR_NONE; all data outputs 0.
- States: KEY, VARINT, FIXED, LEN, EMIT, PAYLOAD, DRAIN.
- KEY: accumulate the key varint. On its final byte (bit7=0), check:
  - field number 0 -> ERR_BAD_FIELD;
  - wire type 3, 4, 6 or 7 -> ERR_BAD_WIRE_TYPE;
  - wt0 -> VARINT; wt1 -> FIXED, 8 bytes; wt5 -> FIXED, 4 bytes; wt2 -> LEN.
- Varint accumulation: byte k contributes bits[6:0] << 7k, LSB group first.
  - 10th byte (MAX_VARINT_BYTES=10) with bit7=1 -> ERR_VARINT_TOO_LONG.
  - Bits [6:1] of the 10th byte are discarded (truncate to 64).
- FIXED: little-endian assembly; byte 0 goes to value[7:0].
- LEN: accumulate the length varint. If length >= 2^MAX_LEN_W -> ERR_LEN_TOO_BIG.
- EMIT: entered the cycle after the field's final byte is accepted, so descriptor latency is 1 cycle.
  - in_ready=0 and fld_valid=1; outputs are stable while fld_ready=0.
  - On handshake: wt2 with length>0 -> PAYLOAD; otherwise -> KEY.
- PAYLOAD: pass-through with zero latency.
  - pay_valid=in_valid, pay_data=in_data, in_ready=pay_ready.
  - A down-counter loaded with the length; pay_last=1 when counter==1. Then -> KEY.
- Zero-length wt2: descriptor with value 0, no payload beats.
- Truncation: in_last accepted on any byte that does not complete the field (key, value or payload) -> ERR_TRUNCATED, state -> KEY.
- in_last on the completing byte: fld_last=1 on that descriptor, or on the pay_last beat for payload.
- Errors:
  - err pulses and err_code updates in the cycle after the offending byte.
  - If the offending byte had in_last, state -> KEY; otherwise -> DRAIN.
  - DRAIN: in_ready=1 and bytes are discarded until a byte with in_last is accepted, then -> KEY.
- fld_valid and pay_valid are never both 1.
- Asserting rst_n low mid-field aborts immediately to reset values. No descriptor is emitted for the partial field.

Optional Feature:
- PB_FIELD_PARSER_STATS_EN defined: adds outputs stat_fields[31:0] and stat_errors[31:0].
  - stat_fields increments on each fld handshake; stat_errors increments on each err pulse.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent.

Decomposition:
- Package pb_hw_pkg holds:
  - pb_wire_type_e (VARINT=0, FIXED64=1, LEN=2, FIXED32=5);
  - pb_err_e (NONE, VARINT_TOO_LONG, BAD_WIRE_TYPE, BAD_FIELD, LEN_TOO_BIG, TRUNCATED);
  - pb_parse_state_e;
  - localparam MAX_VARINT_BYTES=10.
- Sub-module pb_varint_accum handles byte-serial varint accumulation: clear, byte strobe, 64-bit value, done, too_long. It is reused for the key, varint and length phases.

Test Plan:
- Bytes 08 96 01 -> descriptor fld_number=1, wt=0, value=150 (0x96).
- Bytes 12 07 "testing" with in_last on 'g' -> descriptor {2, 2, 7}, then 7 payload beats; pay_last and fld_last on 0x67.
- Bytes 1D 01 02 03 04, then 09 plus 8 bytes FF -> {3, 5, 0x04030201}, then {1, 1, 0xFFFFFFFFFFFFFFFF}.
- Key 08 followed by 10 bytes of 0x80 -> err=1, ERR_VARINT_TOO_LONG; trailing bytes drained until in_last; next message parses.
- Bytes 0B and 00, each with in_last -> ERR_BAD_WIRE_TYPE, then ERR_BAD_FIELD; no descriptors emitted.
- 08 96 with in_last on 96 -> ERR_TRUNCATED.
- 12 03 61 62 63 with fld_ready and pay_ready toggling randomly -> no lost or duplicated bytes; outputs stable while stalled.
